// File: rtl/jmb_filter_frame_scheduler.sv
// rtl/jmb_filter_frame_scheduler.sv - frame-granular round-robin scheduler sharing one scanline filter
// Optional DRAIN watchdog is compiled in with JMB_SCHED_WATCHDOG_EN.
module jmb_filter_frame_scheduler #(
   parameter int DATA_W        = 8,
   parameter int DIM_W         = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [DIM_W-1:0]  width0,
   input  logic [DIM_W-1:0]  height0,
   input  logic [DIM_W-1:0]  width1,
   input  logic [DIM_W-1:0]  height1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic              data_valid0,
   input  logic              data_valid1,
   output logic              data_ready0,
   output logic              data_ready1,
   output logic              grant0,
   output logic              grant1,
   output logic [DATA_W-1:0] filt_data_in,
   output logic [DIM_W-1:0]  filt_width,
   output logic [DIM_W-1:0]  filt_height,
   output logic              filt_enable,
   output logic              filt_reset_n,
   input  logic [DATA_W-1:0] filt_pixel_out,
   input  logic              filt_valid,
   output logic [DATA_W-1:0] pix_out,
   output logic              pix_valid,
   output logic              pix_src,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = 2 * DIM_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              sel_q, sel_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic              grant0_q, grant0_d;
   logic              grant1_q, grant1_d;
   logic              ready0_q, ready0_d;
   logic              ready1_q, ready1_d;
   logic              busy_q, busy_d;
   logic              filt_reset_n_q, filt_reset_n_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic              pix_valid_q, pix_valid_d;
   logic              pix_src_q, pix_src_d;
   logic [DATA_W-1:0] pix_out_q, pix_out_d;

`ifdef JMB_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);
   logic [WD_W-1:0]   drain_cnt_q, drain_cnt_d;
`endif

   logic [DIM_W-1:0]  width_sel;
   logic [DIM_W-1:0]  height_sel;
   logic [DATA_W-1:0] data_sel;
   logic              valid_sel;
   logic              ready_sel;
   logic              accept;
   logic              count_en;
   logic              out_hit;
   logic              in_full;
   logic              out_full;

   assign width_sel  = sel_q ? width1 : width0;
   assign height_sel = sel_q ? height1 : height0;
   assign data_sel   = sel_q ? data1 : data0;
   assign valid_sel  = sel_q ? data_valid1 : data_valid0;
   assign ready_sel  = sel_q ? ready1_q : ready0_q;
   assign accept     = ready_sel & valid_sel;
   assign count_en   = (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign out_hit    = count_en & filt_valid;

   // Ready is only ever high in STREAM for the granted source, so it gates the filter path.
   assign filt_enable  = accept;
   assign filt_data_in = ready_sel ? data_sel : '0;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      sel_d     = sel_q;
      width_d   = width_q;
      height_d  = height_q;
      total_d   = total_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      pix_src_d = pix_src_q;
      frame_err_d = 1'b0;
`ifdef JMB_SCHED_WATCHDOG_EN
      drain_cnt_d = '0;
`endif

      if (accept) begin
         in_cnt_d = in_cnt_q + CNT_W'(1);
      end
      if (out_hit) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
      end
      in_full  = (in_cnt_d == total_q);
      out_full = (out_cnt_d >= total_q);

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d   = S_LOAD;
               sel_d     = (req0 && req1) ? ~last_q : req1;
               pix_src_d = sel_d;
            end
         end
         S_LOAD: begin
            width_d   = width_sel;
            height_d  = height_sel;
            total_d   = CNT_W'(width_sel) * CNT_W'(height_sel);
            in_cnt_d  = '0;
            out_cnt_d = '0;
            if ((width_sel == '0) || (height_sel == '0)) begin
               frame_err_d = 1'b1;
               last_d      = sel_q;
               state_d     = S_IDLE;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_STREAM;
         end
         S_STREAM: begin
            // Output can finish first; completion still waits for the last input beat.
            if (in_full) begin
               state_d = out_full ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_full) begin
               state_d = S_DONE;
            end
`ifdef JMB_SCHED_WATCHDOG_EN
            else if (drain_cnt_q == WD_W'(DRAIN_TIMEOUT - 1)) begin
               frame_err_d = 1'b1;
               last_d      = sel_q;
               state_d     = S_IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + WD_W'(1);
            end
`endif
         end
         S_DONE: begin
            last_d  = sel_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      grant0_d       = (state_d != S_IDLE) && !sel_d;
      grant1_d       = (state_d != S_IDLE) && sel_d;
      ready0_d       = (state_d == S_STREAM) && !sel_d;
      ready1_d       = (state_d == S_STREAM) && sel_d;
      busy_d         = (state_d != S_IDLE);
      filt_reset_n_d = (state_d != S_CLEAR);
      frame_done_d   = (state_d == S_DONE);
      pix_valid_d    = out_hit;
      pix_out_d      = out_hit ? filt_pixel_out : pix_out_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         last_q         <= 1'b1;
         sel_q          <= 1'b0;
         width_q        <= '0;
         height_q       <= '0;
         total_q        <= '0;
         in_cnt_q       <= '0;
         out_cnt_q      <= '0;
         grant0_q       <= 1'b0;
         grant1_q       <= 1'b0;
         ready0_q       <= 1'b0;
         ready1_q       <= 1'b0;
         busy_q         <= 1'b0;
         filt_reset_n_q <= 1'b1;
         frame_done_q   <= 1'b0;
         frame_err_q    <= 1'b0;
         pix_valid_q    <= 1'b0;
         pix_src_q      <= 1'b0;
         pix_out_q      <= '0;
`ifdef JMB_SCHED_WATCHDOG_EN
         drain_cnt_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         last_q         <= last_d;
         sel_q          <= sel_d;
         width_q        <= width_d;
         height_q       <= height_d;
         total_q        <= total_d;
         in_cnt_q       <= in_cnt_d;
         out_cnt_q      <= out_cnt_d;
         grant0_q       <= grant0_d;
         grant1_q       <= grant1_d;
         ready0_q       <= ready0_d;
         ready1_q       <= ready1_d;
         busy_q         <= busy_d;
         filt_reset_n_q <= filt_reset_n_d;
         frame_done_q   <= frame_done_d;
         frame_err_q    <= frame_err_d;
         pix_valid_q    <= pix_valid_d;
         pix_src_q      <= pix_src_d;
         pix_out_q      <= pix_out_d;
`ifdef JMB_SCHED_WATCHDOG_EN
         drain_cnt_q    <= drain_cnt_d;
`endif
      end
   end

   assign data_ready0  = ready0_q;
   assign data_ready1  = ready1_q;
   assign grant0       = grant0_q;
   assign grant1       = grant1_q;
   assign busy         = busy_q;
   assign filt_width   = width_q;
   assign filt_height  = height_q;
   assign filt_reset_n = filt_reset_n_q;
   assign frame_done   = frame_done_q;
   assign frame_err    = frame_err_q;
   assign pix_valid    = pix_valid_q;
   assign pix_out      = pix_out_q;
   assign pix_src      = pix_src_q;

endmodule

// File: tb/tb_jmb_filter_frame_scheduler.sv
// tb/tb_jmb_filter_frame_scheduler.sv - directed table-driven bench for jmb_filter_frame_scheduler
// Watchdog sequence runs only when JMB_SCHED_WATCHDOG_EN is defined.
module tb_jmb_filter_frame_scheduler;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req0, req1;
   logic [15:0] width0, height0, width1, height1;
   logic [7:0]  data0 = 8'h10;
   logic [7:0]  data1 = 8'h80;
   logic        dv0 = 1'b0;
   logic        dv1 = 1'b0;
   logic        ready0, ready1, grant0, grant1;
   logic [7:0]  filt_data_in;
   logic [15:0] filt_width, filt_height;
   logic        filt_enable, filt_reset_n;
   logic [7:0]  filt_pixel_out;
   logic        filt_valid;
   logic [7:0]  pix_out;
   logic        pix_valid, pix_src, frame_done, frame_err, busy;

   logic        tog0, tog1, spur;
   int          mdl_limit;

   always #5 clock = ~clock;

   jmb_filter_frame_scheduler #(.DATA_W(8), .DIM_W(16), .DRAIN_TIMEOUT(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1),
      .width0(width0), .height0(height0), .width1(width1), .height1(height1),
      .data0(data0), .data1(data1),
      .data_valid0(dv0), .data_valid1(dv1),
      .data_ready0(ready0), .data_ready1(ready1),
      .grant0(grant0), .grant1(grant1),
      .filt_data_in(filt_data_in), .filt_width(filt_width), .filt_height(filt_height),
      .filt_enable(filt_enable), .filt_reset_n(filt_reset_n),
      .filt_pixel_out(filt_pixel_out), .filt_valid(filt_valid),
      .pix_out(pix_out), .pix_valid(pix_valid), .pix_src(pix_src),
      .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
   );

   // Sources: free-running pixel data, valid either constant or toggling each cycle.
   always @(posedge clock) begin
      data0 <= data0 + 8'd3;
      data1 <= data1 + 8'd7;
      dv0   <= tog0 ? ~dv0 : 1'b1;
      dv1   <= tog1 ? ~dv1 : 1'b1;
   end

   // Filter model: one-cycle latency, pixel scrambled with 0x5A, at most mdl_limit valids per frame.
   logic       mdl_valid = 1'b0;
   logic [7:0] mdl_pix = 8'h00;
   int         sent = 0;
   always @(posedge clock) begin
      if (!filt_reset_n) begin
         mdl_valid <= 1'b0;
         sent      <= 0;
      end else if (filt_enable && sent < mdl_limit) begin
         mdl_valid <= 1'b1;
         mdl_pix   <= filt_data_in ^ 8'h5A;
         sent      <= sent + 1;
      end else begin
         mdl_valid <= 1'b0;
      end
   end
   assign filt_valid     = mdl_valid | spur;
   assign filt_pixel_out = mdl_pix;

   // Monitor: running counts and protocol-violation tallies sampled on the falling edge.
   int   pv_cnt = 0, fd_cnt = 0, fe_cnt = 0, frst_cnt = 0, scyc = 0, beats = 0;
   int   in_sum = 0, out_sum = 0;
   int   viol_ready = 0, viol_en = 0, viol_data = 0, viol_lag = 0;
   int   order_q[$];
   logic pg0 = 1'b0, pg1 = 1'b0, prev_fv = 1'b0;
   logic [7:0] prev_fp = 8'h00;
   always @(negedge clock) begin
      if (reset_n) begin
         pv_cnt   <= pv_cnt + int'(pix_valid);
         fd_cnt   <= fd_cnt + int'(frame_done);
         fe_cnt   <= fe_cnt + int'(frame_err);
         frst_cnt <= frst_cnt + int'(!filt_reset_n);
         scyc     <= scyc + int'(ready0 | ready1);
         beats    <= beats + int'(filt_enable);
         if ((ready0 && !grant0) || (ready1 && !grant1) || (ready0 && ready1))
            viol_ready <= viol_ready + 1;
         if (filt_enable !== ((ready0 && dv0) || (ready1 && dv1)))
            viol_en <= viol_en + 1;
         if ((ready0 && filt_data_in !== data0) || (ready1 && filt_data_in !== data1))
            viol_data <= viol_data + 1;
         if (pix_valid && (!prev_fv || pix_out !== prev_fp))
            viol_lag <= viol_lag + 1;
         if (filt_enable) in_sum <= in_sum + int'(filt_data_in ^ 8'h5A);
         if (pix_valid) out_sum <= out_sum + int'(pix_out);
         if (grant0 && !pg0) order_q.push_back(0);
         if (grant1 && !pg1) order_q.push_back(1);
         pg0 <= grant0;
         pg1 <= grant1;
         prev_fv <= filt_valid & busy;
         prev_fp <= filt_pixel_out;
      end else begin
         pg0 <= 1'b0;
         pg1 <= 1'b0;
         prev_fv <= 1'b0;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, int'(busy), 0);
      @(negedge clock);
   endtask

   task automatic wait_grants(input int target, input int budget);
      int n = 0;
      while (order_q.size() < target && n < budget) begin
         @(negedge clock);
         n++;
      end
   endtask

   typedef struct {
      logic src;
      int   w;
      int   h;
      logic tog;
      int   pv;
      int   done;
      int   err;
   } vec_t;

   task automatic run_frame(input vec_t v);
      int pv0 = pv_cnt, fd0 = fd_cnt, fe0 = fe_cnt, fr0 = frst_cnt;
      int sc0 = scyc, bt0 = beats, is0 = in_sum, os0 = out_sum;
      int sd, n;
      n = v.w * v.h;
      if (v.src) begin width1 = 16'(v.w); height1 = 16'(v.h); tog1 = v.tog; req1 = 1'b1; end
      else       begin width0 = 16'(v.w); height0 = 16'(v.h); tog0 = v.tog; req0 = 1'b1; end
      @(negedge clock);
      check("grant_latency", int'({grant1, grant0}), v.src ? 2 : 1);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clock);
      if (v.err != 0) begin
         check("err_pulse_at_load_exit", int'({frame_err, grant1, grant0}), 4);
      end else begin
         check("clear_filt_reset_low", int'(filt_reset_n), 0);
         @(negedge clock);
         check("stream_ready", int'(v.src ? ready1 : ready0), 1);
      end
      wait_idle("frame_timeout", 3000);
      check("pix_valid_count", pv_cnt - pv0, v.pv);
      check("frame_done_count", fd_cnt - fd0, v.done);
      check("frame_err_count", fe_cnt - fe0, v.err);
      check("filt_reset_pulses", frst_cnt - fr0, (v.err != 0) ? 0 : 1);
      check("pix_src", int'(pix_src), int'(v.src));
      check("filt_width", int'(filt_width), v.w);
      check("filt_height", int'(filt_height), v.h);
      check("accepted_beats", beats - bt0, v.pv);
      check("pixel_checksum", out_sum - os0, in_sum - is0);
      sd = scyc - sc0;
      if (v.tog) check("bp_stream_cycles", int'(sd >= 2 * n - 1 && sd <= 2 * n), 1);
      else       check("stream_cycles", sd, (v.err != 0) ? 0 : n);
      tog0 = 1'b0;
      tog1 = 1'b0;
   endtask

   vec_t vecs[7];

   initial begin
      int pv0, fd0, fe0, fr0, n0, bt0, is0, os0;
      vecs[0] = '{1'b0, 15, 10, 1'b0, 150, 1, 0};
      vecs[1] = '{1'b1,  4,  2, 1'b0,   8, 1, 0};
      vecs[2] = '{1'b0,  4,  4, 1'b1,  16, 1, 0};
      vecs[3] = '{1'b1,  0,  5, 1'b0,   0, 0, 1};
      vecs[4] = '{1'b0,  3,  0, 1'b0,   0, 0, 1};
      vecs[5] = '{1'b1,  1,  1, 1'b0,   1, 1, 0};
      vecs[6] = '{1'b0,  2,  3, 1'b0,   6, 1, 0};

      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      width0 = '0; height0 = '0; width1 = '0; height1 = '0;
      tog0 = 1'b0; tog1 = 1'b0; spur = 1'b0;
      mdl_limit = 1 << 20;
      repeat (3) @(negedge clock);
      check("rst_grant_ready", int'({grant1, grant0, ready1, ready0}), 0);
      check("rst_enable_pixvalid", int'({filt_enable, pix_valid}), 0);
      check("rst_done_err_busy", int'({frame_done, frame_err, busy}), 0);
      check("rst_filt_reset_n", int'(filt_reset_n), 1);
      check("rst_data_regs", int'({pix_src, pix_out, filt_width, filt_height}), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 7; i++) run_frame(vecs[i]);

      // Round robin with both sources requesting; last winner was source 0.
      width0 = 16'd4; height0 = 16'd2; width1 = 16'd4; height1 = 16'd2;
      n0 = order_q.size(); fd0 = fd_cnt; pv0 = pv_cnt;
      req0 = 1'b1; req1 = 1'b1;
      wait_grants(n0 + 4, 600);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle("rr_timeout", 200);
      check("rr_grant_count", order_q.size() - n0, 4);
      for (int i = 0; i < 4 && n0 + i < order_q.size(); i++)
         check("rr_order", order_q[n0 + i], (i % 2 == 0) ? 1 : 0);
      check("rr_done_count", fd_cnt - fd0, 4);
      check("rr_pix_count", pv_cnt - pv0, 32);

      // Zero-width request from source 1 is rejected, then source 0 runs.
      width1 = 16'd0; height1 = 16'd3; width0 = 16'd2; height0 = 16'd2;
      n0 = order_q.size(); fd0 = fd_cnt; fe0 = fe_cnt; fr0 = frst_cnt; pv0 = pv_cnt;
      req0 = 1'b1; req1 = 1'b1;
      wait_grants(n0 + 2, 100);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle("zd_timeout", 200);
      check("zd_grant_count", order_q.size() - n0, 2);
      for (int i = 0; i < 2 && n0 + i < order_q.size(); i++)
         check("zd_order", order_q[n0 + i], (i == 0) ? 1 : 0);
      check("zd_err_count", fe_cnt - fe0, 1);
      check("zd_done_count", fd_cnt - fd0, 1);
      check("zd_clear_count", frst_cnt - fr0, 1);
      check("zd_pix_count", pv_cnt - pv0, 4);

      // Stray filter valids while idle must not reach pix_valid.
      pv0 = pv_cnt;
      spur = 1'b1;
      repeat (3) @(negedge clock);
      spur = 1'b0;
      repeat (2) @(negedge clock);
      check("idle_valid_ignored", pv_cnt - pv0, 0);

      // Reset in the middle of a 4x4 frame.
      width0 = 16'd4; height0 = 16'd4;
      bt0 = beats;
      req0 = 1'b1;
      for (int k = 0; k < 50 && beats - bt0 < 5; k++) @(negedge clock);
      req0 = 1'b0;
      check("mid_stream_reached", int'(ready0), 1);
      reset_n = 1'b0;
      #1;
      check("midrst_grant_ready", int'({grant1, grant0, ready1, ready0}), 0);
      check("midrst_enable_pixvalid", int'({filt_enable, pix_valid}), 0);
      check("midrst_busy", int'(busy), 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // After reset, source 0 has priority; the next frame runs cleanly.
      width0 = 16'd2; height0 = 16'd2; width1 = 16'd2; height1 = 16'd2;
      fd0 = fd_cnt; pv0 = pv_cnt; is0 = in_sum; os0 = out_sum;
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clock);
      check("post_rst_priority", int'({grant1, grant0}), 1);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle("post_rst_timeout", 200);
      check("post_rst_done", fd_cnt - fd0, 1);
      check("post_rst_pix_count", pv_cnt - pv0, 4);
      check("post_rst_checksum", out_sum - os0, in_sum - is0);

`ifdef JMB_SCHED_WATCHDOG_EN
      begin
         int since = 0;
         int k = 0;
         width0 = 16'd4; height0 = 16'd4;
         mdl_limit = 15;
         fd0 = fd_cnt; fe0 = fe_cnt; pv0 = pv_cnt;
         req0 = 1'b1;
         @(negedge clock);
         req0 = 1'b0;
         while (!frame_err && k < 200) begin
            @(negedge clock);
            since = ready0 ? 0 : since + 1;
            k++;
         end
         check("wd_err_seen", int'(frame_err), 1);
         check("wd_err_latency", since, 9);
         @(negedge clock);
         check("wd_no_done", fd_cnt - fd0, 0);
         check("wd_err_count", fe_cnt - fe0, 1);
         check("wd_pix_count", pv_cnt - pv0, 15);
         check("wd_busy", int'(busy), 0);
         mdl_limit = 1 << 20;
      end
`endif

      check("viol_ready_nongranted", viol_ready, 0);
      check("viol_enable_mirror", viol_en, 0);
      check("viol_data_path", viol_data, 0);
      check("viol_pix_lag", viol_lag, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
